// File: rtl/truth_table_checker.sv
// Clocked truth-table sweep checker: drives every input vector of an N-input
// function, waits SETTLE cycles, samples the SoP/PoS outputs and scores them against EXPECT.
module truth_table_checker #(
  parameter int                N      = 2,
  parameter int                SETTLE = 1,
  parameter logic [(1<<N)-1:0] EXPECT = 4'b0110
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [N-1:0]        vec,
  input  logic                s1,
  input  logic                s2,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [(1<<N)-1:0]   sop_table,
  output logic [(1<<N)-1:0]   pos_table,
  output logic [N:0]          err_count,
  output logic [N-1:0]        first_err
);

  localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N-1:0]  VEC_LAST = {N{1'b1}};
  localparam logic [N-1:0]  VEC_ONE  = N'(1);
  localparam logic [N:0]    ERR_ONE  = (N+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SAMPLE, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            w_settled;
  logic            w_last;
  logic            w_exp;
  logic            w_mismatch;
  logic            w_accept;

  assign w_settled  = (r_cnt == CW'(SETTLE - 1));
  assign w_last     = (vec == VEC_LAST);
  assign w_exp      = EXPECT[vec];
  assign w_mismatch = (s1 != w_exp) | (s2 != w_exp);
  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_accept) w_next = S_HOLD;
      S_HOLD:         if (w_settled) w_next = S_SAMPLE;
      S_SAMPLE:       w_next = w_last ? S_DONE : S_HOLD;
      default:        w_next = S_IDLE;
    endcase
  end

  // Datapath: everything here is an output, so reset clears it along with control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec       <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      sop_table <= '0;
      pos_table <= '0;
      err_count <= '0;
      first_err <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            vec       <= '0;
            r_cnt     <= '0;
            sop_table <= '0;
            pos_table <= '0;
            err_count <= '0;
            first_err <= '0;
            pass      <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        S_HOLD: r_cnt <= r_cnt + CW'(1);
        S_SAMPLE: begin
          sop_table[vec] <= s1;
          pos_table[vec] <= s2;
          if (w_mismatch) begin
            err_count <= err_count + ERR_ONE;
            pass      <= 1'b0;
            // A zero count means no earlier vector has failed in this sweep.
            if (err_count == '0) first_err <= vec;
          end
          if (w_last) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            vec   <= vec + VEC_ONE;
            r_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: default 2-input XOR instance and a 3-input
// majority instance with SETTLE=3, driven from stored truth tables of the function under test.
module tb_truth_table_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic startA, startB;

  logic [1:0] vecA;
  logic [3:0] tA1, tA2;
  logic       s1A, s2A, busyA, doneA, passA;
  logic [3:0] sopA, posA;
  logic [2:0] errA;
  logic [1:0] firstA;

  logic [2:0] vecB;
  logic [7:0] tB1, tB2;
  logic       s1B, s2B, busyB, doneB, passB;
  logic [7:0] sopB, posB;
  logic [3:0] errB;
  logic [2:0] firstB;

  assign s1A = tA1[vecA];
  assign s2A = tA2[vecA];
  assign s1B = tB1[vecB];
  assign s2B = tB2[vecB];

  truth_table_checker dutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .vec(vecA), .s1(s1A), .s2(s2A),
    .busy(busyA), .done(doneA), .pass(passA), .sop_table(sopA), .pos_table(posA),
    .err_count(errA), .first_err(firstA)
  );

  truth_table_checker #(.N(3), .SETTLE(3), .EXPECT(8'b1110_1000)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .vec(vecB), .s1(s1B), .s2(s2B),
    .busy(busyB), .done(doneB), .pass(passB), .sop_table(sopB), .pos_table(posB),
    .err_count(errB), .first_err(firstB)
  );

  localparam logic [3:0] EA = 4'b0110;
  localparam logic [7:0] EB = 8'b1110_1000;

  int tests = 0;
  int failed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: a vector is bad if either implementation disagrees with the expected table.
  function automatic int model_err(input int n, input logic [7:0] e, t1, t2);
    int c = 0;
    for (int i = 0; i < (1 << n); i++) if (t1[i] != e[i] || t2[i] != e[i]) c++;
    return c;
  endfunction

  function automatic int model_first(input int n, input logic [7:0] e, t1, t2);
    for (int i = 0; i < (1 << n); i++) if (t1[i] != e[i] || t2[i] != e[i]) return i;
    return 0;
  endfunction

  // Called #1 after a rising edge; returns cycles from accept edge to done and anomaly count.
  task automatic run_a(input logic [3:0] t1, t2, input int poke, output int cyc, output int bad);
    tA1 = t1; tA2 = t2; bad = 0;
    startA = 1'b1;
    @(posedge clk); #1;
    startA = 1'b0;
    chk("a_start_busy", busyA, 1);
    chk("a_start_done", doneA, 0);
    chk("a_start_clear", {sopA, posA, errA, firstA}, 0);
    chk("a_start_pass", passA, 1);
    cyc = 0;
    while (!doneA && cyc < 200) begin
      if (vecA != 2'(cyc / 2)) bad++;
      if (busyA !== 1'b1) bad++;
      startA = (cyc == poke);
      @(posedge clk); #1;
      cyc++;
      startA = 1'b0;
    end
    if (busyA !== 1'b0) bad++;
    if (vecA !== 2'd3) bad++;
  endtask

  task automatic run_b(input logic [7:0] t1, t2, output int cyc, output int bad);
    tB1 = t1; tB2 = t2; bad = 0;
    startB = 1'b1;
    @(posedge clk); #1;
    startB = 1'b0;
    chk("b_start_busy", busyB, 1);
    cyc = 0;
    while (!doneB && cyc < 400) begin
      if (vecB != 3'(cyc / 4)) bad++;
      if (busyB !== 1'b1) bad++;
      @(posedge clk); #1;
      cyc++;
    end
    if (busyB !== 1'b0) bad++;
    if (vecB !== 3'd7) bad++;
  endtask

  task automatic check_a(input string tg, input logic [3:0] es, ep, input logic epass,
                         input int eerr, input int efirst);
    chk({tg, "_sop"}, sopA, es);
    chk({tg, "_pos"}, posA, ep);
    chk({tg, "_pass"}, passA, epass);
    chk({tg, "_err"}, errA, eerr);
    chk({tg, "_first"}, firstA, efirst);
  endtask

  task automatic check_b(input string tg, input logic [7:0] es, ep, input logic epass,
                         input int eerr, input int efirst);
    chk({tg, "_sop"}, sopB, es);
    chk({tg, "_pos"}, posB, ep);
    chk({tg, "_pass"}, passB, epass);
    chk({tg, "_err"}, errB, eerr);
    chk({tg, "_first"}, firstB, efirst);
  endtask

  typedef struct {
    string      nm;
    logic [3:0] t1;
    logic [3:0] t2;
    logic       epass;
    int         eerr;
    int         efirst;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, bad;
    logic [3:0] r1, r2;
    logic [7:0] q1, q2, inv;

    tbl[0] = '{"xor_xor",   4'b0110, 4'b0110, 1'b1, 0, 0};
    tbl[1] = '{"xor_stuck", 4'b0110, 4'b0000, 1'b0, 2, 1};
    tbl[2] = '{"xnor_xnor", 4'b1001, 4'b1001, 1'b0, 4, 0};
    tbl[3] = '{"pos_bit1",  4'b0110, 4'b0100, 1'b0, 1, 1};

    rst_n = 1'b0; startA = 1'b0; startB = 1'b0;
    tA1 = '0; tA2 = '0; tB1 = '0; tB2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ctl", {vecA, busyA, doneA, passA}, 0);
    chk("rst_a_data", {sopA, posA, errA, firstA}, 0);
    chk("rst_b_ctl", {vecB, busyB, doneB, passB}, 0);
    chk("rst_b_data", {sopB, posB, errB, firstB}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      run_a(tbl[i].t1, tbl[i].t2, -1, cyc, bad);
      chk({tbl[i].nm, "_cycles"}, cyc, 8);
      chk({tbl[i].nm, "_seq"}, bad, 0);
      check_a(tbl[i].nm, tbl[i].t1, tbl[i].t2, tbl[i].epass, tbl[i].eerr, tbl[i].efirst);
    end

    // start pulsed mid-sweep must not disturb timing
    run_a(4'b0110, 4'b0110, 3, cyc, bad);
    chk("poke_cycles", cyc, 8);
    chk("poke_seq", bad, 0);
    check_a("poke", 4'b0110, 4'b0110, 1'b1, 0, 0);
    @(posedge clk); #1;
    chk("done_hold", doneA, 1);

    // reset in the middle of a sweep
    tA1 = 4'b0110; tA2 = 4'b0110;
    startA = 1'b1;
    @(posedge clk); #1;
    startA = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ctl", {vecA, busyA, doneA, passA}, 0);
    chk("midrst_data", {sopA, posA, errA, firstA}, 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_idle", {busyA, doneA}, 0);
    run_a(4'b0110, 4'b0110, -1, cyc, bad);
    chk("after_rst_cycles", cyc, 8);
    chk("after_rst_seq", bad, 0);
    check_a("after_rst", 4'b0110, 4'b0110, 1'b1, 0, 0);

    // reset and start at the same edge
    rst_n = 1'b0; startA = 1'b1;
    @(posedge clk); #1;
    chk("rst_start_busy", busyA, 0);
    chk("rst_start_done", doneA, 0);
    rst_n = 1'b1; startA = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_idle", busyA, 0);

    for (int k = 0; k < 8; k++) begin
      r1 = 4'($urandom);
      r2 = 4'($urandom);
      if ($urandom_range(0, 2) == 0) r1 = EA;
      if ($urandom_range(0, 2) == 0) r2 = EA;
      run_a(r1, r2, -1, cyc, bad);
      chk("rnd_a_cycles", cyc, 8);
      chk("rnd_a_seq", bad, 0);
      check_a("rnd_a", r1, r2, model_err(2, {4'b0, EA}, {4'b0, r1}, {4'b0, r2}) == 0,
              model_err(2, {4'b0, EA}, {4'b0, r1}, {4'b0, r2}),
              model_first(2, {4'b0, EA}, {4'b0, r1}, {4'b0, r2}));
    end

    run_b(EB, EB, cyc, bad);
    chk("maj_cycles", cyc, 32);
    chk("maj_seq", bad, 0);
    check_b("maj", EB, EB, 1'b1, 0, 0);

    inv = ~EB;
    run_b(inv, EB, cyc, bad);
    chk("maj_inv_cycles", cyc, 32);
    check_b("maj_inv", inv, EB, 1'b0, 8, 0);

    for (int k = 0; k < 4; k++) begin
      q1 = 8'($urandom);
      q2 = (k == 0) ? EB : 8'($urandom);
      run_b(q1, q2, cyc, bad);
      chk("rnd_b_cycles", cyc, 32);
      chk("rnd_b_seq", bad, 0);
      check_b("rnd_b", q1, q2, model_err(3, EB, q1, q2) == 0,
              model_err(3, EB, q1, q2), model_first(3, EB, q1, q2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
